// File: rtl/apb_fsm_controller.sv
// APB master sequencer for the AHB-to-APB bridge: walks SETUP/ENABLE phases
// from the AHB-side valid flag and pipelined address/data copies, stalling AHB via hready_out.
module apb_fsm_controller #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int NSEL   = 3
) (
   input  logic              hclk,
   input  logic              hresetn,
   input  logic              valid,
   input  logic              hwrite,
   input  logic              hwrite_reg,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [ADDR_W-1:0] haddr_1,
   input  logic [ADDR_W-1:0] haddr_2,
   input  logic [DATA_W-1:0] hwdata,
   input  logic [DATA_W-1:0] hwdata_1,
   output logic              pwrite,
   output logic              penable,
   output logic [NSEL-1:0]   psel,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   output logic              hready_out
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_WWAIT, ST_READ, ST_WRITE, ST_WRITEP,
      ST_RENABLE, ST_WENABLE, ST_WENABLEP
   } state_t;

   state_t              state, state_nxt;
   logic                bad_state;
   logic                pwrite_nxt, penable_nxt, hready_nxt;
   logic [NSEL-1:0]     psel_nxt;
   logic [ADDR_W-1:0]   paddr_nxt, waddr;
   logic [DATA_W-1:0]   pwdata_nxt, wdata;

   // Slaves live in 64 MB windows from 0x8000_0000; index comes from addr[27:26].
   function automatic logic [NSEL-1:0] decode(input logic [ADDR_W-1:0] a);
      logic [NSEL-1:0] s;
      s = '0;
      if (a[ADDR_W-1 -: 4] == 4'h8)
         for (int i = 0; i < NSEL; i++)
            if (int'(a[ADDR_W-5 -: 2]) == i) s[i] = 1'b1;
      return s;
   endfunction

   always_comb begin
      state_nxt = state;
      bad_state = 1'b0;
      case (state)
         ST_IDLE:     if (valid) state_nxt = hwrite ? ST_WWAIT : ST_READ;
         ST_WWAIT:    state_nxt = valid ? ST_WRITEP : ST_WRITE;
         ST_READ:     state_nxt = ST_RENABLE;
         ST_WRITE:    state_nxt = valid ? ST_WENABLEP : ST_WENABLE;
         ST_WRITEP:   state_nxt = ST_WENABLEP;
         ST_RENABLE, ST_WENABLE: begin
            if (valid) state_nxt = hwrite ? ST_WWAIT : ST_READ;
            else       state_nxt = ST_IDLE;
         end
         ST_WENABLEP: begin
            if (!hwrite_reg) state_nxt = ST_READ;
            else if (valid)  state_nxt = ST_WRITEP;
            else             state_nxt = ST_WRITE;
         end
         default: begin
            state_nxt = ST_IDLE;
            bad_state = 1'b1;
         end
      endcase
   end

   // A write re-entered from WENABLEP is one beat deeper in the AHB pipeline.
   assign waddr = (state == ST_WENABLEP) ? haddr_2  : haddr_1;
   assign wdata = (state == ST_WENABLEP) ? hwdata_1 : hwdata;

   always_comb begin
      psel_nxt    = psel;
      penable_nxt = penable;
      pwrite_nxt  = pwrite;
      paddr_nxt   = paddr;
      pwdata_nxt  = pwdata;
      hready_nxt  = hready_out;
      case (state_nxt)
         ST_READ: begin
            paddr_nxt   = haddr;
            pwrite_nxt  = 1'b0;
            psel_nxt    = decode(haddr);
            penable_nxt = 1'b0;
            hready_nxt  = 1'b0;
         end
         ST_WRITE, ST_WRITEP: begin
            paddr_nxt   = waddr;
            pwdata_nxt  = wdata;
            pwrite_nxt  = 1'b1;
            psel_nxt    = decode(waddr);
            penable_nxt = 1'b0;
            hready_nxt  = 1'b0;
         end
         ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
            penable_nxt = 1'b1;
            hready_nxt  = 1'b1;
         end
         default: begin
            psel_nxt    = '0;
            penable_nxt = 1'b0;
            hready_nxt  = 1'b1;
         end
      endcase
      if (bad_state) begin
         psel_nxt    = '0;
         penable_nxt = 1'b0;
         pwrite_nxt  = 1'b0;
         paddr_nxt   = '0;
         pwdata_nxt  = '0;
         hready_nxt  = 1'b1;
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state      <= ST_IDLE;
         psel       <= '0;
         penable    <= 1'b0;
         pwrite     <= 1'b0;
         paddr      <= '0;
         pwdata     <= '0;
         hready_out <= 1'b1;
      end else begin
         state      <= state_nxt;
         psel       <= psel_nxt;
         penable    <= penable_nxt;
         pwrite     <= pwrite_nxt;
         paddr      <= paddr_nxt;
         pwdata     <= pwdata_nxt;
         hready_out <= hready_nxt;
      end
   end

endmodule
